// File: rtl/ring_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ring_arb_pkg
// Description : Shared constants and helpers for the ring round-robin arbiter:
//               FSM state encoding and a one-hot rotate-by-one function.
// Revision    : 1.0 - initial release
// ============================================================================
package ring_arb_pkg;

   // FSM state encoding
   localparam int         c_STATE_W  = 2;
   localparam logic [1:0] c_IDLE     = 2'd0;
   localparam logic [1:0] c_GRANT    = 2'd1;
   localparam logic [1:0] c_RECOVER  = 2'd2;

   // Widest ring the rotate helper supports
   localparam int         c_ROT_MAXW = 64;

   // Rotate the low n bits of v by one position; left=1 moves toward the
   // higher index (bit n-1 wraps to bit 0), left=0 toward the lower index.
   function automatic logic [c_ROT_MAXW-1:0] rot1(input logic [c_ROT_MAXW-1:0] v,
                                                  input int                    n,
                                                  input logic                  left);
      logic [c_ROT_MAXW-1:0] mask;
      mask = (n >= c_ROT_MAXW) ? '1 : ((64'd1 << n) - 64'd1);
      if (left)
         return ((v << 1) | (v >> (n - 1))) & mask;
      else
         return ((v >> 1) | (v << (n - 1))) & mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ring_prio_pick.sv
`default_nettype none
// ============================================================================
// Module      : ring_prio_pick
// Description : Combinational round-robin pick. Returns the first set request
//               starting at the token position, scanning toward higher
//               (dir=1) or lower (dir=0) indices with wrap. The scan is done
//               by rotating a doubled request vector so the token lands at
//               bit 0, isolating the lowest set bit and rotating back.
// Revision    : 1.0 - initial release
// ============================================================================
module ring_prio_pick #(
   parameter int N = 18
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] token,
   input  logic         dir,
   output logic [N-1:0] pick,
   output logic         valid
);
   localparam int c_IW = (N > 1) ? $clog2(N) : 1;

   logic [c_IW-1:0] w_tok_idx;
   logic [c_IW-1:0] w_start;
   logic [N-1:0]    w_req_rev;
   logic [N-1:0]    w_vec;
   logic [N-1:0]    w_rot;
   logic [N-1:0]    w_iso;
   logic [2*N-1:0]  w_back;
   logic [N-1:0]    w_pos;
   logic [N-1:0]    w_pos_rev;

   // Binary index of the one-hot token
   always_comb begin
      w_tok_idx = '0;
      for (int i = 0; i < N; i++)
         if (token[i]) w_tok_idx = c_IW'(i);
   end

   // Bit-reversed views so a downward scan becomes an upward scan
   always_comb begin
      w_req_rev = '0;
      w_pos_rev = '0;
      for (int i = 0; i < N; i++) begin
         w_req_rev[i] = req[N-1-i];
         w_pos_rev[i] = w_pos[N-1-i];
      end
   end

   assign w_vec   = dir ? req : w_req_rev;
   assign w_start = dir ? w_tok_idx : (c_IW'(N - 1) - w_tok_idx);

   // Bring the start position to bit 0, keep the lowest set bit, rotate back
   assign w_rot  = N'({w_vec, w_vec} >> w_start);
   assign w_iso  = w_rot & (-w_rot);
   assign w_back = {{N{1'b0}}, w_iso} << w_start;
   assign w_pos  = w_back[N-1:0] | w_back[2*N-1:N];

   assign pick  = dir ? w_pos : w_pos_rev;
   assign valid = |req;

endmodule
`default_nettype wire

// File: rtl/ring_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ring_rr_arbiter
// Description : Round-robin arbiter with a one-hot rotating priority token.
//               One requester is granted until it drops req; the token then
//               moves one step past the winner in the dir direction and a
//               dead RECOVER cycle precedes the next arbitration.
//               Optional: define RING_ARB_TIMEOUT_EN to revoke grants held
//               for MAX_HOLD cycles (timeout pulse, requester masked until
//               it drops req).
// Revision    : 1.0 - initial release
// ============================================================================
module ring_rr_arbiter
   import ring_arb_pkg::*;
#(
   parameter int N        = 18,
   parameter int MAX_HOLD = 64
) (
   input  logic                 clk,
   input  logic                 res,
   input  logic [N-1:0]         req,
   input  logic                 dir,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 busy,
   output logic [N-1:0]         token,
   output logic                 timeout
);
   localparam int c_IW = $clog2(N);

   logic [c_STATE_W-1:0] r_state;
   logic [N-1:0]         r_token;
   logic [N-1:0]         r_gnt;
   logic [c_IW-1:0]      r_gnt_id;
   logic                 r_busy;

   logic [N-1:0]         w_req_eff;
   logic [N-1:0]         w_pick;
   logic                 w_valid;
   logic [c_IW-1:0]      w_pick_id;
   logic [N-1:0]         w_tok_next;
   logic                 w_req_lost;
   logic                 w_expire;
   logic                 w_drop;

   // Winner still requesting?
   assign w_req_lost = ~|(req & r_gnt);
   assign w_drop     = w_req_lost | w_expire;

`ifdef RING_ARB_TIMEOUT_EN
   localparam int              c_CNT_W     = $clog2(MAX_HOLD + 1);
   localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(MAX_HOLD - 1);

   logic [c_CNT_W-1:0] r_cnt;
   logic [N-1:0]       r_mask;
   logic               r_timeout;

   assign w_expire  = (r_state == c_GRANT) && !w_req_lost && (r_cnt == c_HOLD_LAST);
   assign w_req_eff = req & ~r_mask;
   assign timeout   = r_timeout;

   // Hold counter, timeout pulse and re-compete mask (bit clears once req drops)
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         r_cnt     <= '0;
         r_mask    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_cnt     <= (r_state == c_GRANT) ? r_cnt + c_CNT_W'(1) : '0;
         r_mask    <= (r_mask & req) | (w_expire ? r_gnt : '0);
         r_timeout <= w_expire;
      end
   end
`else
   logic [31:0] w_unused_hold;

   assign w_unused_hold = MAX_HOLD;
   assign w_expire      = 1'b0;
   assign w_req_eff     = req;
   assign timeout       = 1'b0;
`endif

   ring_prio_pick #(.N(N)) u_pick (
      .req   (w_req_eff),
      .token (r_token),
      .dir   (dir),
      .pick  (w_pick),
      .valid (w_valid)
   );

   // Binary index of the picked requester
   always_comb begin
      w_pick_id = '0;
      for (int i = 0; i < N; i++)
         if (w_pick[i]) w_pick_id = c_IW'(i);
   end

   assign w_tok_next = N'(rot1(64'(r_gnt), N, dir));

   // Arbitration FSM: pick in IDLE, hold in GRANT, one dead cycle in RECOVER
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         r_state  <= c_IDLE;
         r_token  <= N'(1);
         r_gnt    <= '0;
         r_gnt_id <= '0;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_valid) begin
                  r_gnt    <= w_pick;
                  r_gnt_id <= w_pick_id;
                  r_busy   <= 1'b1;
                  r_state  <= c_GRANT;
               end
            end
            c_GRANT: begin
               if (w_drop) begin
                  r_token  <= w_tok_next;
                  r_gnt    <= '0;
                  r_gnt_id <= '0;
                  r_busy   <= 1'b0;
                  r_state  <= c_RECOVER;
               end
            end
            c_RECOVER: r_state <= c_IDLE;
            default:   r_state <= c_IDLE;
         endcase
      end
   end

   assign gnt    = r_gnt;
   assign gnt_id = r_gnt_id;
   assign busy   = r_busy;
   assign token  = r_token;

endmodule
`default_nettype wire
